// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential PC increment, wrapping modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage

// File: rtl/fetch_ctrl_ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
module ifid_reg
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4,
  output logic        o_valid
);

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;

  // Flush only drops the valid bit; payload is retained.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr <= NOP;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_instr <= i_instr;
      r_pc4   <= i_pc4;
      r_valid <= 1'b1;
    end
  end

  assign o_instr = r_instr;
  assign o_pc4   = r_pc4;
  assign o_valid = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC update, IM handshake and IF/ID ownership.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] PC,
  output logic [31:0] Next_PC,
  output logic        PC_EN,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic        IM_Req,
  output logic [31:0] IM_Addr,
  input  logic        IM_Ack,
  input  logic [31:0] IM_Data,
  input  logic        Stall,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_Valid
);

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [31:0]  r_hold_buf;
  logic [31:0]  r_saved_addr;

  logic [31:0]  w_pc4;
  logic         w_slot_free;
  logic         w_ifid_load;
  logic         w_ifid_flush;
  logic [31:0]  w_ifid_instr;
  logic         w_hold_capture;
  logic         w_pc_en;
  logic [31:0]  w_next_pc;
  logic         w_im_req;
  logic [31:0]  w_im_addr;

  assign w_pc4       = pc_plus4(PC);
  assign w_slot_free = !IFID_Valid || !Stall;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_en        = 1'b0;
    w_next_pc      = w_pc4;
    w_im_req       = 1'b0;
    w_im_addr      = PC;
    w_ifid_load    = 1'b0;
    w_ifid_flush   = 1'b0;
    w_ifid_instr   = IM_Data;
    w_hold_capture = 1'b0;

    unique case (r_state)
      BOOT: begin
        w_pc_en     = 1'b1;
        w_next_pc   = RESET_PC;
        w_state_nxt = REQ;
      end

      REQ: begin
        w_im_req = 1'b1;
        if (Branch_Taken) begin
          w_ifid_flush = 1'b1;
          w_pc_en      = 1'b1;
          w_next_pc    = Branch_Target;
          w_state_nxt  = IM_Ack ? REQ : DRAIN;
        end else if (IM_Ack) begin
          if (w_slot_free) begin
            w_ifid_load = 1'b1;
            w_pc_en     = 1'b1;
          end else begin
            w_hold_capture = 1'b1;
            w_state_nxt    = HOLD;
          end
        end else if (w_slot_free) begin
          w_ifid_flush = 1'b1;
        end
      end

      HOLD: begin
        if (Branch_Taken) begin
          w_ifid_flush = 1'b1;
          w_pc_en      = 1'b1;
          w_next_pc    = Branch_Target;
          w_state_nxt  = REQ;
        end else if (!Stall) begin
          w_ifid_load  = 1'b1;
          w_ifid_instr = r_hold_buf;
          w_pc_en      = 1'b1;
          w_state_nxt  = REQ;
        end
      end

      DRAIN: begin
        // The abandoned request must stay on the bus until acknowledged.
        w_im_req  = 1'b1;
        w_im_addr = r_saved_addr;
        if (Branch_Taken) begin
          w_ifid_flush = 1'b1;
          w_pc_en      = 1'b1;
          w_next_pc    = Branch_Target;
        end else if (IM_Ack) begin
          w_state_nxt = REQ;
        end
      end

      default: w_state_nxt = BOOT;
    endcase

    // Keeps a reset-less PC register initialised while RST is held.
    if (RST) begin
      w_pc_en   = 1'b1;
      w_next_pc = RESET_PC;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= BOOT;
      r_hold_buf   <= NOP;
      r_saved_addr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == REQ) begin
        r_saved_addr <= PC;
      end
      if (w_hold_capture) begin
        r_hold_buf <= IM_Data;
      end
    end
  end

  ifid_reg u_ifid_reg (
    .clk     (CLK),
    .rst     (RST),
    .i_load  (w_ifid_load),
    .i_flush (w_ifid_flush),
    .i_instr (w_ifid_instr),
    .i_pc4   (w_pc4),
    .o_instr (IFID_Instr),
    .o_pc4   (IFID_PC4),
    .o_valid (IFID_Valid)
  );

  assign PC_EN   = w_pc_en;
  assign Next_PC = w_next_pc;
  assign IM_Req  = w_im_req;
  assign IM_Addr = w_im_addr;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a reset-less PC register model.
module tb_fetch_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PC;
  logic [31:0] Next_PC;
  logic        PC_EN;
  logic        Branch_Taken;
  logic [31:0] Branch_Target;
  logic        IM_Req;
  logic [31:0] IM_Addr;
  logic        IM_Ack;
  logic [31:0] IM_Data;
  logic        Stall;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PC4;
  logic        IFID_Valid;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (PC_EN) PC <= Next_PC;
  end

  assign IM_Data = IM_Addr | 32'hA000_0000;

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .PC            (PC),
    .Next_PC       (Next_PC),
    .PC_EN         (PC_EN),
    .Branch_Taken  (Branch_Taken),
    .Branch_Target (Branch_Target),
    .IM_Req        (IM_Req),
    .IM_Addr       (IM_Addr),
    .IM_Ack        (IM_Ack),
    .IM_Data       (IM_Data),
    .Stall         (Stall),
    .IFID_Instr    (IFID_Instr),
    .IFID_PC4      (IFID_PC4),
    .IFID_Valid    (IFID_Valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_pc_en"}, {31'b0, PC_EN}, 32'd1);
    chk({tag, "_next_pc"}, Next_PC, 32'h0);
    chk({tag, "_im_req"}, {31'b0, IM_Req}, 32'd0);
    chk({tag, "_valid"}, {31'b0, IFID_Valid}, 32'd0);
  endtask

  initial begin
    RST = 1'b1; IM_Ack = 1'b0; Stall = 1'b0;
    Branch_Taken = 1'b0; Branch_Target = 32'h0;
    #2;
    chk_reset_outs("rst0");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_reset_outs("rst");
    end
    RST = 1'b0;
    #1;
    chk("boot_pc_en", {31'b0, PC_EN}, 32'd1);
    chk("boot_im_req", {31'b0, IM_Req}, 32'd0);
    tick();
    chk("req0_im_req", {31'b0, IM_Req}, 32'd1);
    chk("req0_addr", IM_Addr, 32'h0);

    // zero-wait stream
    IM_Ack = 1'b1;
    tick();
    chk("s0_pc4", IFID_PC4, 32'd4);
    chk("s0_instr", IFID_Instr, 32'hA000_0000);
    chk("s0_valid", {31'b0, IFID_Valid}, 32'd1);
    tick();
    chk("s1_pc4", IFID_PC4, 32'd8);
    chk("s1_instr", IFID_Instr, 32'hA000_0004);
    tick();
    chk("s2_pc4", IFID_PC4, 32'd12);
    chk("s2_instr", IFID_Instr, 32'hA000_0008);

    // reset mid-operation
    RST = 1'b1; IM_Ack = 1'b0;
    #1;
    chk_reset_outs("mrst");
    tick();
    RST = 1'b0;
    tick();
    IM_Ack = 1'b1;
    tick();
    chk("r_pc4", IFID_PC4, 32'd4);
    tick();
    chk("r2_pc4", IFID_PC4, 32'd8);
    chk("r2_instr", IFID_Instr, 32'hA000_0004);

    // stall with ack for 0x8 arriving
    Stall = 1'b1;
    #1;
    chk("st_pc_en", {31'b0, PC_EN}, 32'd0);
    chk("st_addr", IM_Addr, 32'h8);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("hold_im_req", {31'b0, IM_Req}, 32'd0);
      chk("hold_pc", PC, 32'h8);
      chk("hold_pc4", IFID_PC4, 32'd8);
      chk("hold_instr", IFID_Instr, 32'hA000_0004);
      chk("hold_valid", {31'b0, IFID_Valid}, 32'd1);
    end
    Stall = 1'b0;
    #1;
    chk("unst_pc_en", {31'b0, PC_EN}, 32'd1);
    chk("unst_next_pc", Next_PC, 32'hC);
    tick();
    chk("unst_pc4", IFID_PC4, 32'd12);
    chk("unst_instr", IFID_Instr, 32'hA000_0008);
    chk("unst_im_req", {31'b0, IM_Req}, 32'd1);
    chk("unst_addr", IM_Addr, 32'hC);
    tick();
    chk("c_pc4", IFID_PC4, 32'd16);

    // redirect coinciding with ack for 0x10
    Branch_Taken = 1'b1; Branch_Target = 32'h100;
    #1;
    chk("rda_next_pc", Next_PC, 32'h100);
    chk("rda_pc_en", {31'b0, PC_EN}, 32'd1);
    tick();
    Branch_Taken = 1'b0; IM_Ack = 1'b0;
    chk("rda_valid", {31'b0, IFID_Valid}, 32'd0);
    chk("rda_addr", IM_Addr, 32'h100);
    chk("rda_pc4_kept", IFID_PC4, 32'd16);

    // redirect while the request at 0x100 is pending
    tick();
    chk("rdp_wait_addr", IM_Addr, 32'h100);
    Branch_Taken = 1'b1; Branch_Target = 32'h10;
    #1;
    chk("rdp_next_pc", Next_PC, 32'h10);
    tick();
    Branch_Taken = 1'b0;
    chk("drain_req", {31'b0, IM_Req}, 32'd1);
    chk("drain_addr", IM_Addr, 32'h100);
    chk("drain_valid", {31'b0, IFID_Valid}, 32'd0);
    IM_Ack = 1'b1;
    #1;
    chk("drain_ack_pc_en", {31'b0, PC_EN}, 32'd0);
    tick();
    IM_Ack = 1'b0;
    chk("post_drain_addr", IM_Addr, 32'h10);
    chk("post_drain_req", {31'b0, IM_Req}, 32'd1);
    chk("post_drain_valid", {31'b0, IFID_Valid}, 32'd0);
    chk("post_drain_pc4", IFID_PC4, 32'd16);

    // jump to 0xFFFF_FFFC, then wrap
    Branch_Taken = 1'b1; Branch_Target = 32'hFFFF_FFFC; IM_Ack = 1'b1;
    tick();
    Branch_Taken = 1'b0;
    chk("wrap_addr", IM_Addr, 32'hFFFF_FFFC);
    #1;
    chk("wrap_next_pc", Next_PC, 32'h0);
    tick();
    chk("wrap_pc4", IFID_PC4, 32'h0);
    chk("wrap_instr", IFID_Instr, 32'hFFFF_FFFC);
    chk("wrap_addr0", IM_Addr, 32'h0);

    // redirect while holding a buffered word
    Stall = 1'b1;
    tick();
    chk("hf_im_req", {31'b0, IM_Req}, 32'd0);
    Branch_Taken = 1'b1; Branch_Target = 32'h40;
    #1;
    chk("hf_next_pc", Next_PC, 32'h40);
    tick();
    Branch_Taken = 1'b0; Stall = 1'b0; IM_Ack = 1'b0;
    chk("hf_valid", {31'b0, IFID_Valid}, 32'd0);
    chk("hf_addr", IM_Addr, 32'h40);
    tick();
    chk("hf_valid2", {31'b0, IFID_Valid}, 32'd0);
    chk("hf_instr", IFID_Instr, 32'hFFFF_FFFC);
    chk("hf_pc4", IFID_PC4, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
